uart_record_rx: RTL and testbench

- Receive end of the TDC record UART link: deserialises 8N1 UART bytes and reassembles 5-byte records into 40-bit TDC words.
- Bytes arrive MSB-first (byte 0 = bits [39:32]).
- Used on the host-side or loopback FPGA to check the TDC transmit path.
- Drops partial records on framing error or inter-byte timeout, so the stream resynchronises.

---
 rtl/tdc_link_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 125 ++++++++++++
 rtl/uart_record_rx.sv | 104 ++++++++++
 tb/tb_uart_record_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_link_pkg.sv
// rtl/tdc_link_pkg.sv - constants and types shared by the TDC record UART link
//
// Purpose: record geometry, the default UART bit period and the byte
// receiver state encoding. The TDC transmit side uses the same constants.
// Ports: none (package).
package tdc_link_pkg;

  localparam int RECORD_BYTES         = 5;
  localparam int RECORD_W             = 8 * RECORD_BYTES;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchroniser
//
// Purpose: synchronises rx, detects start bits, samples 8 data bits LSB
// first at mid-bit and checks the stop bit.
// Ports:
//   clk, reset    system clock, synchronous active-low reset
//   rx            asynchronous serial input, idles high
//   byte_data     last received byte (valid while byte_valid is high)
//   byte_valid    one-cycle pulse at mid stop bit when the stop bit is 1
//   byte_err      one-cycle pulse when the stop bit is sampled 0
//   start_det     one-cycle pulse when a start edge is taken in IDLE
//   idle          receiver FSM is in IDLE
module uart_rx_byte
  import tdc_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       start_det,
  output logic       idle
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic            rx_meta, rx_s, rx_d;
  rx_state_t       state, state_next;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_q;
  logic            timer_clr, data_tick;

  // Synchroniser and edge-detect history load 1 so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    data_tick  = 1'b0;
    start_det  = 1'b0;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_clr = 1'b1;
        if (rx_d && !rx_s) begin
          start_det  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (timer == HALF_M1) begin
          timer_clr  = 1'b1;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (timer == FULL_M1) begin
          timer_clr = 1'b1;
          data_tick = 1'b1;
          if (bit_idx == 3'd7) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timer == FULL_M1) begin
          timer_clr = 1'b1;
          if (rx_s) begin
            byte_valid = 1'b1;
            state_next = ST_IDLE;
          end else begin
            byte_err   = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a stuck-low line is one error.
        timer_clr = 1'b1;
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer   <= '0;
      bit_idx <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      timer <= timer_clr ? '0 : timer + 1'b1;
      if (state == ST_START) bit_idx <= 3'd0;
      if (data_tick) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign byte_data = shift_q;
  assign idle      = (state == ST_IDLE);

endmodule

// File: rtl/uart_record_rx.sv
// rtl/uart_record_rx.sv - reassembles UART bytes into TDC records
//
// Purpose: collects BYTES_PER_RECORD bytes (first byte in the MSBs) into one
// record, discarding partial records on framing error or inter-byte timeout.
// Ports:
//   clk, reset    system clock, synchronous active-low reset
//   rx            asynchronous serial input, idles high
//   record_data   last complete record, byte 0 in the top byte
//   record_valid  one-cycle pulse when record_data updates
//   frame_error   one-cycle pulse on a low stop bit
//   timeout       one-cycle pulse when a partial record is dropped on timeout
//   err_count     saturating count of frame errors plus timeouts
//   busy          byte receiver active or a partial record is held
module uart_record_rx
  import tdc_link_pkg::*;
#(
  parameter int CLKS_PER_BIT     = DEFAULT_CLKS_PER_BIT,
  parameter int BYTES_PER_RECORD = RECORD_BYTES,
  parameter int TIMEOUT_CLKS     = 20 * DEFAULT_CLKS_PER_BIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [8*BYTES_PER_RECORD-1:0] record_data,
  output logic                          record_valid,
  output logic                          frame_error,
  output logic                          timeout,
  output logic [7:0]                    err_count,
  output logic                          busy
);

  localparam int RW = 8 * BYTES_PER_RECORD;
  localparam int IW = (BYTES_PER_RECORD > 1) ? $clog2(BYTES_PER_RECORD) : 1;
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_RECORD - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);

  logic [7:0]    byte_data;
  logic          byte_valid, byte_err, start_det, idle;
  logic [RW-1:0] acc, acc_next;
  logic [IW-1:0] idx;
  logic [CW-1:0] idle_cnt;
  logic          to_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .start_det (start_det),
    .idle      (idle)
  );

  assign acc_next = (acc << 8) | RW'(byte_data);

  // A start edge in the same cycle as expiry keeps the partial record.
  assign to_hit = idle && !start_det && (idx != '0) && (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc          <= '0;
      idx          <= '0;
      idle_cnt     <= '0;
      record_data  <= '0;
      record_valid <= 1'b0;
      frame_error  <= 1'b0;
      timeout      <= 1'b0;
      err_count    <= 8'h00;
    end else begin
      record_valid <= 1'b0;
      frame_error  <= 1'b0;
      timeout      <= 1'b0;

      if (byte_err) begin
        idx         <= '0;
        frame_error <= 1'b1;
      end else if (byte_valid) begin
        acc <= acc_next;
        if (idx == LAST_IDX) begin
          record_data  <= acc_next;
          record_valid <= 1'b1;
          idx          <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (to_hit) begin
        idx     <= '0;
        timeout <= 1'b1;
      end

      if (!idle || start_det || (idx == '0) || to_hit) idle_cnt <= '0;
      else                                             idle_cnt <= idle_cnt + 1'b1;

      if ((byte_err || to_hit) && (err_count != 8'hFF)) err_count <= err_count + 8'h01;
    end
  end

  assign busy = !idle || (idx != '0);

endmodule

// File: tb/tb_uart_record_rx.sv
// tb/tb_uart_record_rx.sv - directed self-checking bench for uart_record_rx
module tb_uart_record_rx;

  localparam int CPB = 16;
  localparam int TO  = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [39:0] record_data;
  logic        record_valid, frame_error, timeout, busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [39:0] rec_q[$];
  int fe_cnt = 0;
  int to_cnt = 0;

  uart_record_rx #(
    .CLKS_PER_BIT    (CPB),
    .BYTES_PER_RECORD(5),
    .TIMEOUT_CLKS    (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .record_data (record_data),
    .record_valid(record_valid),
    .frame_error (frame_error),
    .timeout     (timeout),
    .err_count   (err_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (record_valid) rec_q.push_back(record_data);
      if (frame_error) fe_cnt++;
      if (timeout) to_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap_bits);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop;
    wait_clks(CPB);
    if (stop) begin
      rx = 1'b1;
      wait_clks(gap_bits * CPB);
    end
  endtask

  task automatic send_record(input logic [39:0] r);
    for (int i = 4; i >= 0; i--) send_byte(r[8*i +: 8], 1'b1, 1);
    wait_clks(2 * CPB);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    reset = 1'b0;
    wait_clks(4);
    @(negedge clk);
    check("rst_record_data", 64'(record_data), 64'h0);
    check("rst_pulses", {61'h0, record_valid, frame_error, timeout}, 64'h0);
    check("rst_err_count", 64'(err_count), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_clks(4);
  endtask

  initial begin
    do_reset();

    // Single record
    rec_q.delete();
    send_record(40'h123456789A);
    check("t1_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() > 0) check("t1_data", 64'(rec_q[0]), 64'h123456789A);
    check("t1_err", 64'(err_count), 64'h0);
    check("t1_busy", 64'(busy), 64'h0);

    // Back-to-back records
    rec_q.delete();
    send_record(40'h0001020304);
    send_record(40'hFFFEFDFCFB);
    check("t2_count", 64'(rec_q.size()), 64'd2);
    if (rec_q.size() > 1) begin
      check("t2_first", 64'(rec_q[0]), 64'h0001020304);
      check("t2_second", 64'(rec_q[1]), 64'hFFFEFDFCFB);
    end
    check("t2_hold", 64'(record_data), 64'hFFFEFDFCFB);

    // Framing error, held-low line, then resync
    rec_q.delete();
    fe_cnt = 0;
    send_byte(8'hAA, 1'b1, 1);
    send_byte(8'hBB, 1'b0, 0);
    wait_clks(50);
    rx = 1'b1;
    wait_clks(3 * CPB);
    check("t3_fe", 64'(fe_cnt), 64'd1);
    check("t3_norec", 64'(rec_q.size()), 64'd0);
    check("t3_err", 64'(err_count), 64'd1);
    check("t3_busy", 64'(busy), 64'h0);
    send_record(40'h1122334455);
    check("t3_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() > 0) check("t3_data", 64'(rec_q[0]), 64'h1122334455);
    check("t3_fe_after", 64'(fe_cnt), 64'd1);

    // Timeout on a partial record, then resync
    do_reset();
    rec_q.delete();
    to_cnt = 0;
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h02, 1'b1, 1);
    send_byte(8'h03, 1'b1, 1);
    check("t4_busy_partial", 64'(busy), 64'h1);
    wait_clks(TO + 50);
    check("t4_timeout", 64'(to_cnt), 64'd1);
    check("t4_err", 64'(err_count), 64'd1);
    check("t4_busy", 64'(busy), 64'h0);
    check("t4_norec", 64'(rec_q.size()), 64'd0);
    send_record(40'h0102030405);
    check("t4_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() > 0) check("t4_data", 64'(rec_q[0]), 64'h0102030405);

    // Short glitch is a false start
    rec_q.delete();
    fe_cnt = 0;
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(3 * CPB);
    check("t5_glitch_rec", 64'(rec_q.size()), 64'd0);
    check("t5_glitch_fe", 64'(fe_cnt), 64'd0);
    check("t5_glitch_err", 64'(err_count), 64'd1);
    check("t5_glitch_busy", 64'(busy), 64'h0);

    // Reset during byte 3 of a record
    send_byte(8'hA0, 1'b1, 1);
    send_byte(8'hA1, 1'b1, 1);
    rx = 1'b0;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(3 * CPB);
    do_reset();
    wait_clks(2 * CPB);
    rec_q.delete();
    send_record(40'hA1B2C3D4E5);
    check("t5_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() > 0) check("t5_data", 64'(rec_q[0]), 64'hA1B2C3D4E5);
    check("t5_err", 64'(err_count), 64'd0);

    // Saturation of err_count
    fe_cnt = 0;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h00, 1'b0, 0);
      rx = 1'b1;
      wait_clks(2 * CPB);
      if (i == 253) check("t6_err_254", 64'(err_count), 64'd254);
    end
    check("t6_fe_cnt", 64'(fe_cnt), 64'd260);
    check("t6_sat", 64'(err_count), 64'hFF);
    send_byte(8'h00, 1'b0, 0);
    rx = 1'b1;
    wait_clks(2 * CPB);
    check("t6_sat_hold", 64'(err_count), 64'hFF);
    check("t6_fe_last", 64'(fe_cnt), 64'd261);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
